// File: rtl/fetch_decode_reg.sv
// Fetch->decode pipeline register with a one-entry skid buffer, a bubble on I-mem miss,
// flush of all held instructions, and a saturating count of bubble cycles.

package isa_pkg;
  parameter int XLEN = 32;
  parameter int ILEN = 32;

  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } slot_t;
endpackage

module fetch_decode_reg
  import isa_pkg::*;
#(
  parameter logic [ILEN-1:0] BUBBLE_INSTR = 32'h0000_0013,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  src_pc,
  input  logic [ILEN-1:0]  src_instr,
  input  logic             hazi_miss,
  input  logic             hazi_stall,
  input  logic             hazi_flush,
  output logic             hazo_stall,
  output logic             dst_valid,
  output logic [XLEN-1:0]  dst_pc,
  output logic [ILEN-1:0]  dst_instr,
  output logic [CNT_W-1:0] perfo_bubbles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  slot_t            m_q;
  slot_t            s_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // The skid being occupied is the only thing that blocks fetch, so the stall to the
  // PC register comes straight from a flop.
  assign accept = !hazi_miss && !s_q.v;

  // NOTE: every state element, data fields included, gets a reset value so dst_pc is
  // deterministic from the first cycle; these are plain flops, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees the
      // pre-edge values of m_q, s_q and cnt_q.
      if (!m_q.v && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (hazi_flush) begin
        m_q.v <= 1'b0;
        s_q.v <= 1'b0;
      end else if (!hazi_stall) begin
        if (s_q.v) begin
          m_q   <= s_q;
          s_q.v <= 1'b0;
        end else begin
          m_q.v <= accept;
          if (accept) begin
            m_q.pc    <= src_pc;
            m_q.instr <= src_instr;
          end
        end
      end else if (accept) begin
        // Decode is stalled: M holds even if it is a bubble, and the new pair waits in the skid.
        s_q.v     <= 1'b1;
        s_q.pc    <= src_pc;
        s_q.instr <= src_instr;
      end
    end
  end

  assign hazo_stall    = s_q.v;
  assign dst_valid     = m_q.v;
  assign dst_pc        = m_q.pc;
  assign dst_instr     = m_q.v ? m_q.instr : BUBBLE_INSTR;
  assign perfo_bubbles = cnt_q;

endmodule
